// File: rtl/pulse_osc_pkg.sv
// Shared types for the pulse oscillator: output modes and the configuration record
// exchanged between the top level and the shadow register pair.
package pulse_osc_pkg;

  // Config fields are sized for the widest supported instance; each module uses the low bits.
  localparam int CFG_MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_MUTE   = 2'd2
  } mode_e;

  typedef struct packed {
    mode_e                mode;
    logic [CFG_MAX_W-1:0] period;
    logic [CFG_MAX_W-1:0] high;
    logic [CFG_MAX_W-1:0] amp;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{mode: MODE_MUTE, period: '0, high: '0, amp: '0};

  // Encoding 3 is reserved and behaves as mute.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    return (raw == 2'd3) ? MODE_MUTE : mode_e'(raw);
  endfunction

endpackage

// File: rtl/pulse_osc_shadow.sv
// Pending/active configuration pair: one-deep shadow slot, ready flag and the rule
// deciding when the pending config becomes active.
module pulse_osc_shadow
  import pulse_osc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  input  logic cfg_valid,
  input  cfg_t cfg_in,
  output logic cfg_ready,
  output cfg_t active,
  output cfg_t active_next
);

  logic pend_valid;
  cfg_t pend;
  logic accept;
  logic apply;
  logic direct;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    accept      = en && cfg_valid && !pend_valid;
    apply       = pend_valid && (!en || restart);
    direct      = !en && cfg_valid && !pend_valid;
    active_next = active;
    if (apply) begin
      active_next = pend;
    end else if (direct) begin
      active_next = cfg_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      active     <= CFG_RESET;
    end else begin
      active <= active_next;
      if (apply) begin
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_valid <= 1'b1;
      end
    end
  end

  // NOTE: the pending payload has no reset; pend_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (reset_n && accept) begin
      pend <= cfg_in;
    end
  end

  assign cfg_ready = !pend_valid;

endmodule

// File: rtl/pulse_osc.sv
// Square/pulse oscillator: 1-based period counter, wrap strobe and a signed +/-amp
// sample that is registered together with the counter so both always agree.
module pulse_osc
  import pulse_osc_pkg::*;
#(
  parameter int SAMPLE_W = 32,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic                       phase_rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [1:0]                 cfg_mode,
  input  logic [CNT_W-1:0]           cfg_period,
  input  logic [CNT_W-1:0]           cfg_high,
  input  logic [SAMPLE_W-2:0]        cfg_amp,
  output logic signed [SAMPLE_W-1:0] out,
  output logic [CNT_W-1:0]           counter,
  output logic                       wrap
);

  cfg_t cfg_in;
  cfg_t active;
  cfg_t active_next;

  logic [CNT_W-1:0]           period;
  logic [CNT_W-1:0]           period_next;
  logic [CNT_W-1:0]           high_next;
  logic [SAMPLE_W-2:0]        amp_next;
  logic [CNT_W-1:0]           threshold;
  logic [CNT_W-1:0]           counter_next;
  logic signed [SAMPLE_W-1:0] amp_s;
  logic signed [SAMPLE_W-1:0] out_next;
  logic                       period_end;
  logic                       restart;
  logic                       wrap_next;
  logic                       unused_cfg;

  always_comb begin
    cfg_in                   = '0;
    cfg_in.mode              = decode_mode(cfg_mode);
    cfg_in.period[CNT_W-1:0] = cfg_period;
    cfg_in.high[CNT_W-1:0]   = cfg_high;
    cfg_in.amp[SAMPLE_W-2:0] = cfg_amp;
  end

  // With period 0 every cycle counts as a restart, so a pending config can still land.
  pulse_osc_shadow u_shadow (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .restart     (restart),
    .cfg_valid   (cfg_valid),
    .cfg_in      (cfg_in),
    .cfg_ready   (cfg_ready),
    .active      (active),
    .active_next (active_next)
  );

  assign period      = active.period[CNT_W-1:0];
  assign period_next = active_next.period[CNT_W-1:0];
  assign high_next   = active_next.high[CNT_W-1:0];
  assign amp_next    = active_next.amp[SAMPLE_W-2:0];
  assign unused_cfg  = ^{active, active_next};

  // Compare before increment: counter never exceeds period, so +1 cannot overflow.
  assign period_end   = counter >= period;
  assign restart      = period_end || phase_rst;
  assign counter_next = restart ? CNT_W'(1) : counter + CNT_W'(1);
  assign wrap_next    = period_end && !phase_rst && (period != '0);

  assign threshold = (active_next.mode == MODE_SQUARE) ? (period_next >> 1) : high_next;
  assign amp_s     = {1'b0, amp_next};

  always_comb begin
    out_next = '0;
    if (active_next.mode != MODE_MUTE && period_next >= CNT_W'(2)) begin
      out_next = (counter_next <= threshold) ? amp_s : -amp_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      counter <= CNT_W'(1);
      out     <= '0;
      wrap    <= 1'b0;
    end else begin
      counter <= counter_next;
      out     <= out_next;
      wrap    <= wrap_next;
    end
  end

endmodule

// File: tb/tb_pulse_osc.sv
// Self-checking bench for pulse_osc: directed scenarios plus a random run, all
// compared every cycle against a cycle-level behavioural model of the oscillator.
module tb_pulse_osc;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 8;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                en;
  logic                phase_rst;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [1:0]          cfg_mode;
  logic [CNT_W-1:0]    cfg_period;
  logic [CNT_W-1:0]    cfg_high;
  logic [SAMPLE_W-2:0] cfg_amp;
  logic [SAMPLE_W-1:0] out;
  logic [CNT_W-1:0]    counter;
  logic                wrap;

  always #5 clk = ~clk;

  pulse_osc #(.SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .phase_rst  (phase_rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_amp    (cfg_amp),
    .out        (out),
    .counter    (counter),
    .wrap       (wrap)
  );

  typedef struct {
    int mode;
    int period;
    int high;
    int amp;
  } mcfg_t;

  mcfg_t               m_act;
  mcfg_t               m_pend[$];
  int                  m_cnt;
  logic [SAMPLE_W-1:0] m_out;
  bit                  m_wrap;
  string               phase;
  int                  vectors = 0;
  int                  miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample for position pos of a period: +amp while inside the high phase, -amp after it.
  function automatic logic [SAMPLE_W-1:0] ref_out(input mcfg_t c, input int pos);
    logic signed [SAMPLE_W-1:0] a;
    int thr;
    if (c.mode >= 2 || c.period < 2) return '0;
    thr = (c.mode == 0) ? c.period / 2 : c.high;
    a = SAMPLE_W'(c.amp);
    return (pos <= thr) ? a : -a;
  endfunction

  task automatic model_edge();
    mcfg_t offered;
    bit    ended;
    bit    restart;
    offered = '{int'(cfg_mode), int'(cfg_period), int'(cfg_high), int'(cfg_amp)};
    if (!reset_n) begin
      m_cnt  = 1;
      m_out  = '0;
      m_wrap = 0;
      m_pend.delete();
      m_act  = '{2, 0, 0, 0};
    end else if (!en) begin
      m_cnt  = 1;
      m_out  = '0;
      m_wrap = 0;
      if (m_pend.size() != 0) m_act = m_pend.pop_front();
      else if (cfg_valid)     m_act = offered;
    end else begin
      ended   = m_cnt >= m_act.period;
      restart = ended || phase_rst;
      m_wrap  = ended && !phase_rst && m_act.period != 0;
      if (restart && m_pend.size() != 0) m_act = m_pend.pop_front();
      else if (cfg_valid && m_pend.size() == 0) m_pend.push_back(offered);
      m_cnt = restart ? 1 : m_cnt + 1;
      m_out = ref_out(m_act, m_cnt);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check({phase, ".out"}, 64'(out), 64'(m_out));
    check({phase, ".counter"}, 64'(counter), 64'(m_cnt));
    check({phase, ".wrap"}, 64'(wrap), 64'(m_wrap));
    check({phase, ".cfg_ready"}, 64'(cfg_ready), 64'(m_pend.size() == 0));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic offer(input int mode, input int period, input int high, input int amp);
    int n = 0;
    cfg_mode   = 2'(mode);
    cfg_period = CNT_W'(period);
    cfg_high   = CNT_W'(high);
    cfg_amp    = (SAMPLE_W-1)'(amp);
    cfg_valid  = 1'b1;
    while (m_pend.size() != 0 && n < 64) begin
      cycle();
      n++;
    end
    check({phase, ".offer_ready"}, 64'(cfg_ready), 64'(1));
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int target, input int bound);
    int n = 0;
    while (m_cnt != target && n < bound) begin
      cycle();
      n++;
    end
    check({phase, ".reach_cnt"}, 64'(counter), 64'(target));
  endtask

  task automatic wait_wrap(input int bound);
    int n = 0;
    while (!m_wrap && n < bound) begin
      cycle();
      n++;
    end
    check({phase, ".wrap_seen"}, 64'(wrap), 64'(1));
  endtask

  initial begin
    logic [SAMPLE_W-1:0] pos_amp;
    logic [SAMPLE_W-1:0] neg_amp;
    int n;
    int wraps;

    m_act  = '{2, 0, 0, 0};
    m_cnt  = 1;
    m_out  = '0;
    m_wrap = 0;

    // Reset with a config offered at the same time: it must not be taken.
    phase      = "reset";
    reset_n    = 1'b0;
    en         = 1'b0;
    phase_rst  = 1'b0;
    cfg_valid  = 1'b1;
    cfg_mode   = 2'd1;
    cfg_period = CNT_W'(5);
    cfg_high   = CNT_W'(2);
    cfg_amp    = (SAMPLE_W-1)'(9);
    run(3);
    check("reset.out_zero", 64'(out), 64'(0));
    check("reset.counter_one", 64'(counter), 64'(1));
    cfg_valid = 1'b0;
    reset_n   = 1'b1;
    run(2);

    // Square wave, period 8.
    phase = "square";
    offer(0, 8, 0, 1000);
    check("square.ready_high_en0", 64'(cfg_ready), 64'(1));
    en      = 1'b1;
    pos_amp = SAMPLE_W'(1000);
    neg_amp = -pos_amp;
    wraps   = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (wrap) wraps++;
      if (counter <= 4) check("square.out_high", 64'(out), 64'(pos_amp));
      else              check("square.out_low", 64'(out), 64'(neg_amp));
    end
    check("square.wrap_count", 64'(wraps), 64'(3));

    // Pulse period 10/high 3, then a period-4 config offered mid-period.
    phase = "pulse";
    offer(1, 10, 3, 5);
    wait_wrap(16);
    run(9);
    wait_wrap(4);
    wait_cnt(5, 16);
    cfg_mode   = 2'd1;
    cfg_period = CNT_W'(4);
    cfg_high   = CNT_W'(1);
    cfg_amp    = (SAMPLE_W-1)'(5);
    cfg_valid  = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    n = 0;
    while (!cfg_ready && n < 20) begin
      n++;
      cycle();
    end
    check("pulse.ready_low_cycles", 64'(n), 64'(5));
    check("pulse.full_period_wrap", 64'(wrap), 64'(1));
    run(8);

    // phase_rst at counter 5 restarts without wrap and applies the pending config.
    phase = "phase_rst";
    offer(0, 8, 0, 1000);
    wait_wrap(8);
    wait_cnt(2, 8);
    offer(1, 8, 2, 9);
    wait_cnt(5, 8);
    phase_rst = 1'b1;
    cycle();
    phase_rst = 1'b0;
    check("phase_rst.counter", 64'(counter), 64'(1));
    check("phase_rst.no_wrap", 64'(wrap), 64'(0));
    check("phase_rst.applied_ready", 64'(cfg_ready), 64'(1));
    check("phase_rst.new_out", 64'(out), 64'(9));
    run(10);

    // PULSE extremes: high=0 is constant -amp, high >= period is constant +amp.
    phase   = "pulse_edge";
    pos_amp = SAMPLE_W'(50);
    neg_amp = -pos_amp;
    offer(1, 10, 0, 50);
    wait_wrap(12);
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("pulse_edge.high0", 64'(out), 64'(neg_amp));
    end
    offer(1, 10, 20, 50);
    wait_wrap(12);
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("pulse_edge.high20", 64'(out), 64'(pos_amp));
    end

    // Period 1: silent, wrap every cycle. Period 0: counter parked at 1, never wraps.
    phase = "short";
    offer(0, 1, 0, 7);
    wait_wrap(12);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("short.p1_out", 64'(out), 64'(0));
      check("short.p1_wrap", 64'(wrap), 64'(1));
    end
    offer(0, 0, 0, 7);
    run(2);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("short.p0_counter", 64'(counter), 64'(1));
      check("short.p0_wrap", 64'(wrap), 64'(0));
    end

    // Disabled: config lands at once, ready never drops; first wrap a full period after enable.
    phase = "en_low";
    en    = 1'b0;
    cycle();
    offer(0, 6, 0, 3);
    check("en_low.ready_high", 64'(cfg_ready), 64'(1));
    en = 1'b1;
    n  = 0;
    while (!wrap && n < 20) begin
      cycle();
      n++;
    end
    check("en_low.first_wrap", 64'(n), 64'(6));

    // Reset mid-period, with a config offered in the same cycle.
    phase = "reset_mid";
    wait_cnt(3, 10);
    reset_n    = 1'b0;
    cfg_valid  = 1'b1;
    cfg_mode   = 2'd0;
    cfg_period = CNT_W'(9);
    cycle();
    cfg_valid = 1'b0;
    reset_n   = 1'b1;
    check("reset_mid.out", 64'(out), 64'(0));
    check("reset_mid.counter", 64'(counter), 64'(1));
    check("reset_mid.ready", 64'(cfg_ready), 64'(1));
    run(3);

    // Largest representable period.
    phase = "max_period";
    en    = 1'b0;
    offer(0, 255, 0, 100);
    en = 1'b1;
    n  = 0;
    while (!wrap && n < 300) begin
      cycle();
      n++;
    end
    check("max_period.first_wrap", 64'(n), 64'(255));

    // Random traffic against the model.
    phase = "random";
    en    = 1'b0;
    offer(1, 12, 5, 300);
    for (int i = 0; i < 1500; i++) begin
      en         = ($urandom_range(0, 15) != 0);
      phase_rst  = ($urandom_range(0, 31) == 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_period = CNT_W'($urandom_range(1, 20));
      cfg_high   = CNT_W'($urandom_range(0, 24));
      cfg_amp    = (SAMPLE_W-1)'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
